// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host master: bus widths and FSM states.
package wb_host_pkg;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   // Byte-address increment between consecutive 32-bit beats
   localparam logic [WB_ADR_W-1:0] WB_ADR_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/wb_host_beat_timer.sv
// Per-beat watchdog: counts cycles spent waiting on the slave and flags
// expiry on the TIMEOUT-th cycle so the master can abandon the beat.
module wb_host_beat_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Count enabled cycles from zero; hold at the last value once expired
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   // Expiry marks the final cycle the beat is allowed to stay on the bus
   always_comb begin
      expired = enable && (count == LAST_CNT);
   end

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic master: turns valid/ready commands (single or
// incrementing-address bursts) into one Wishbone cycle per beat and returns
// one response per beat, aborting a beat that the slave never answers.
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int LEN_W   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [WB_ADR_W-1:0] cmd_adr,
   input  logic [WB_DAT_W-1:0] cmd_dat,
   input  logic [WB_SEL_W-1:0] cmd_sel,
   input  logic [LEN_W-1:0]    cmd_len,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WB_DAT_W-1:0] rsp_dat,
   output logic                rsp_err,
   output logic                rsp_last,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [WB_SEL_W-1:0] wbm_sel_o,
   output logic [WB_ADR_W-1:0] wbm_adr_o,
   output logic [WB_DAT_W-1:0] wbm_dat_o,
   input  logic [WB_DAT_W-1:0] wbm_dat_i,
   input  logic                wbm_ack_i,
   input  logic                wbm_err_i
);

   state_t state;
   state_t state_next;

   logic                we_q;
   logic [WB_ADR_W-1:0] adr_q;
   logic [WB_DAT_W-1:0] dat_q;
   logic [WB_SEL_W-1:0] sel_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    beat_q;
   logic [WB_DAT_W-1:0] rsp_dat_q;
   logic                rsp_err_q;
   logic                rsp_last_q;

   logic in_bus;
   logic timer_expired;
   logic beat_end;
   logic beat_err;

   assign in_bus   = (state == ST_BUS);
   assign beat_end = in_bus && (wbm_ack_i || wbm_err_i || timer_expired);
   assign beat_err = wbm_err_i || (!wbm_ack_i && timer_expired);

   wb_host_beat_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_beat_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!in_bus),
      .enable  (in_bus),
      .expired (timer_expired)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept, run one beat, hand back its response
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (cmd_valid)  state_next = ST_BUS;
         ST_BUS:  if (beat_end)   state_next = ST_RESP;
         ST_RESP: if (rsp_ready)  state_next = rsp_last_q ? ST_IDLE : ST_BUS;
         default:                 state_next = ST_IDLE;
      endcase
   end

   // Output decode: handshakes and bus strobes follow the registered state
   always_comb begin
      cmd_ready = (state == ST_IDLE);
      rsp_valid = (state == ST_RESP);
      wbm_cyc_o = (state == ST_BUS);
      wbm_stb_o = (state == ST_BUS);
   end

   // Command capture, per-beat response capture and burst address advance
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         rsp_dat_q  <= '0;
         rsp_err_q  <= 1'b0;
         rsp_last_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  we_q   <= cmd_we;
                  adr_q  <= cmd_adr;
                  dat_q  <= cmd_dat;
                  sel_q  <= cmd_sel;
                  len_q  <= cmd_len;
                  beat_q <= '0;
               end
            end
            ST_BUS: begin
               if (beat_end) begin
                  rsp_err_q  <= beat_err;
                  rsp_dat_q  <= (!we_q && !beat_err) ? wbm_dat_i : '0;
                  rsp_last_q <= beat_err || (beat_q == len_q);
               end
            end
            ST_RESP: begin
               if (rsp_ready && !rsp_last_q) begin
                  adr_q  <= adr_q + WB_ADR_STEP;
                  beat_q <= beat_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign wbm_we_o  = we_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign wbm_sel_o = sel_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_last  = rsp_last_q;

endmodule
